// File: rtl/mem_stall_controller.sv
// ---------------------------------------------------------------------------
// mem_stall_controller
//
// Sequences multi-cycle data-memory accesses for the MEM stage of a 5-stage
// pipeline. While a load/store waits for the memory's req/ack handshake the
// upstream pipeline registers are frozen and bubbles are forced into MEM/WB.
// Load data is held for MEM/WB capture, and a wait that exceeds
// TIMEOUT_CYCLES raises a sticky bus error that software clears via err_clr.
//
// Parameters
//   TIMEOUT_CYCLES  maximum WAIT cycles before ERROR (2 .. 2**CNT_W)
//   CNT_W           width of the wait counter
//
// Ports
//   clk           pipeline clock, rising edge
//   rst           asynchronous active-low reset
//   mem_read      MemRead of the instruction in EX/MEM
//   mem_write     MemWrite of the instruction in EX/MEM
//   dmem_req      registered request to data memory
//   dmem_we       registered write qualifier for dmem_req
//   dmem_ack      one-cycle completion pulse from data memory
//   dmem_rdata    read data, valid only with dmem_ack
//   rdata_out     held load data for MEM/WB ReadDataIn
//   pipe_en       enable for PC, IF/ID, ID/EX, EX/MEM registers
//   memwb_bubble  forces MEM/WB RegWriteIn/MemToRegIn to 0
//   bus_error     sticky timeout flag
//   err_clr       clears bus_error and releases ERROR
//   busy          controller is not idle
// ---------------------------------------------------------------------------
module mem_stall_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] rdata_out,
  output logic        pipe_en,
  output logic        memwb_bubble,
  output logic        bus_error,
  input  logic        err_clr,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_COMPLETE = 3'd2,
    ST_ERROR    = 3'd3,
    ST_DRAIN    = 3'd4
  } state_e;

  // Counter value seen in the last permitted WAIT cycle. The counter starts
  // at 0 in the first WAIT cycle, so WAIT cycle k carries the value k-1.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic access;
  logic timeout_hit;

  // A simultaneous read and write is treated as a write.
  assign access      = mem_read | mem_write;
  assign timeout_hit = (cnt_q == CntLast);

  // State and datapath registers. Reset drops any outstanding request
  // immediately, so dmem_req falls without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and output decode. The default is a full stall with a
  // bubble; only IDLE-without-access, COMPLETE and DRAIN open the pipeline.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    pipe_en      = 1'b0;
    memwb_bubble = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        // Acks arriving here are stray and ignored.
        pipe_en      = !access;
        memwb_bubble = access;
        if (access) begin
          state_d = ST_WAIT;
          req_d   = 1'b1;
          we_d    = mem_write;
          cnt_d   = '0;
        end
      end

      ST_WAIT: begin
        // An ack in the final permitted cycle still completes normally.
        if (dmem_ack) begin
          if (!we_q) begin
            rdata_d = dmem_rdata;
          end
          req_d   = 1'b0;
          state_d = ST_COMPLETE;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_COMPLETE: begin
        // The access instruction moves into MEM/WB and captures rdata_out.
        pipe_en      = 1'b1;
        memwb_bubble = 1'b0;
        state_d      = ST_IDLE;
      end

      ST_ERROR: begin
        // Late acks are ignored; only err_clr leaves this state.
        if (err_clr) begin
          err_d   = 1'b0;
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // The faulting instruction leaves EX/MEM without writing back.
        pipe_en      = 1'b1;
        memwb_bubble = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dmem_req  = req_q;
  assign dmem_we   = we_q;
  assign bus_error = err_q;
  assign rdata_out = rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_mem_stall_controller
//
// Self-checking bench for mem_stall_controller: a constant vector table for
// the basic load/store/back-to-back flows, hand-written sequences for the
// timeout, ack-at-timeout and asynchronous-reset corners, and a randomized
// run compared against a transaction-level reference model.
// Control outputs are compared as the bundle
// {pipe_en, memwb_bubble, busy, dmem_req, dmem_we, bus_error}.
// ---------------------------------------------------------------------------
module tb_mem_stall_controller;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        rdIn;
  logic        wrIn;
  logic        ackIn;
  logic [31:0] rdataIn;
  logic        clrIn;

  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] rdataOut;
  logic        pipeEn;
  logic        memwbBubble;
  logic        busError;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_stall_controller #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (rdIn),
    .mem_write   (wrIn),
    .dmem_req    (dmemReq),
    .dmem_we     (dmemWe),
    .dmem_ack    (ackIn),
    .dmem_rdata  (rdataIn),
    .rdata_out   (rdataOut),
    .pipe_en     (pipeEn),
    .memwb_bubble(memwbBubble),
    .bus_error   (busError),
    .err_clr     (clrIn),
    .busy        (busy)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] ctrlOut;
  assign ctrlOut = {pipeEn, memwbBubble, busy, dmemReq, dmemWe, busError};

  // Reference model: tracks the outstanding transaction rather than a state
  // register. An access is "active" from acceptance until ack or timeout,
  // followed by a one-cycle completion, or a fault held until cleared and a
  // one-cycle drain.
  bit          mActive;
  bit          mIsWrite;
  bit          mLastWe;
  bit          mDone;
  bit          mFault;
  bit          mDrain;
  bit          mErr;
  int          mWaited;
  logic [31:0] mHeld;

  function automatic void modelReset();
    mActive  = 1'b0;
    mIsWrite = 1'b0;
    mLastWe  = 1'b0;
    mDone    = 1'b0;
    mFault   = 1'b0;
    mDrain   = 1'b0;
    mErr     = 1'b0;
    mWaited  = 0;
    mHeld    = 32'h0;
  endfunction

  function automatic bit modelIdle();
    return !mActive && !mDone && !mFault && !mDrain;
  endfunction

  function automatic logic [5:0] modelCtrl();
    bit acc;
    bit idle;
    bit pe;
    bit bub;
    acc  = rdIn | wrIn;
    idle = modelIdle();
    pe   = idle ? !acc : (mDone || mDrain);
    bub  = idle ? acc : !mDone;
    return {pe, bub, !idle, mActive, mLastWe, mErr};
  endfunction

  function automatic void modelEdge();
    if (modelIdle()) begin
      if (rdIn | wrIn) begin
        mActive  = 1'b1;
        mIsWrite = wrIn;
        mLastWe  = wrIn;
        mWaited  = 0;
      end
    end else if (mActive) begin
      mWaited = mWaited + 1;
      if (ackIn) begin
        mActive = 1'b0;
        mDone   = 1'b1;
        if (!mIsWrite) mHeld = rdataIn;
      end else if (mWaited == TIMEOUT) begin
        mActive = 1'b0;
        mFault  = 1'b1;
        mErr    = 1'b1;
      end
    end else if (mDone) begin
      mDone = 1'b0;
    end else if (mFault) begin
      if (clrIn) begin
        mFault = 1'b0;
        mErr   = 1'b0;
        mDrain = 1'b1;
      end
    end else begin
      mDrain = 1'b0;
    end
  endfunction

  task automatic applyStimulus(input logic rd, input logic wr, input logic ack,
                               input logic [31:0] data, input logic clr);
    rdIn    = rd;
    wrIn    = wr;
    ackIn   = ack;
    rdataIn = data;
    clrIn   = clr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Advance one clock: the model sees the same inputs the DUT samples.
  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic        ack;
    logic [31:0] data;
    logic        clr;
    logic [5:0]  expCtrl;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic       pipeEnNow;
    logic [5:0] expCtrl;
    int         pick;

    // Load with ack in WAIT cycle 3
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 6'b010000, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 6'b011100, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 6'b011100, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 6'b011100, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 6'b101000, 32'hDEADBEEF};
    // Back-to-back store then load, each acked in the first WAIT cycle
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 6'b010000, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 6'b011110, 32'hDEADBEEF};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 6'b101010, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 6'b010010, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 6'b011100, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 6'b101000, 32'hCAFEF00D};
    // Spurious ack while idle, then read+write treated as a write
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 6'b100000, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 6'b100000, 32'hCAFEF00D};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 6'b010000, 32'hCAFEF00D};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0, 6'b011110, 32'hCAFEF00D};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 6'b101010, 32'hCAFEF00D};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 6'b100010, 32'hCAFEF00D};

    // Reset state, checked before any clock edge
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    modelReset();
    #2;
    checkOutput("reset ctrl", 32'(ctrlOut), 32'(6'b100000));
    checkOutput("reset rdata", rdataOut, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    stepCycle();

    // Vector table
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].ack, vecs[i].data, vecs[i].clr);
      @(negedge clk);
      checkOutput($sformatf("vec%0d ctrl", i), 32'(ctrlOut), 32'(vecs[i].expCtrl));
      checkOutput($sformatf("vec%0d rdata", i), rdataOut, vecs[i].expRdata);
      stepCycle();
    end

    // Store that times out, late ack ignored, then err_clr and drain
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("tmo idle", 32'(ctrlOut), 32'(6'b010010));
    stepCycle();
    for (int i = 0; i < TIMEOUT - 1; i++) stepCycle();
    @(negedge clk);
    checkOutput("tmo last wait", 32'(ctrlOut), 32'(6'b011110));
    stepCycle();
    @(negedge clk);
    checkOutput("tmo error", 32'(ctrlOut), 32'(6'b011011));
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0BADF00D, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("tmo late ack ctrl", 32'(ctrlOut), 32'(6'b011011));
    checkOutput("tmo late ack rdata", rdataOut, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("tmo drain", 32'(ctrlOut), 32'(6'b111010));
    stepCycle();
    @(negedge clk);
    checkOutput("tmo back idle", 32'(ctrlOut), 32'(6'b100010));

    // Ack in the final WAIT cycle beats the timeout
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    stepCycle();
    for (int i = 0; i < TIMEOUT - 1; i++) stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
    @(negedge clk);
    checkOutput("coincide wait", 32'(ctrlOut), 32'(6'b011100));
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("coincide complete", 32'(ctrlOut), 32'(6'b101000));
    checkOutput("coincide rdata", rdataOut, 32'hA5A5A5A5);
    stepCycle();

    // Asynchronous reset in the middle of WAIT
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    stepCycle();
    stepCycle();
    @(negedge clk);
    checkOutput("pre-reset wait", 32'(ctrlOut), 32'(6'b011100));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset ctrl", 32'(ctrlOut), 32'(6'b010000));
    checkOutput("async reset rdata", rdataOut, 32'h0);
    modelReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    stepCycle();

    // Randomized run against the reference model. The EX/MEM contents only
    // change after an edge on which pipe_en was high.
    pipeEnNow = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if (pipeEnNow) begin
        pick = int'($urandom_range(0, 5));
        rdIn = (pick == 1) || (pick == 2) || (pick == 5);
        wrIn = (pick == 3) || (pick == 4) || (pick == 5);
      end
      ackIn   = ($urandom_range(0, 7) == 0);
      rdataIn = $urandom;
      clrIn   = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      expCtrl = modelCtrl();
      checkOutput($sformatf("rand%0d ctrl", n), 32'(ctrlOut), 32'(expCtrl));
      checkOutput($sformatf("rand%0d rdata", n), rdataOut, mHeld);
      pipeEnNow = expCtrl[5];
      stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stall_controller.md
Name: mem_stall_controller

Overview:
- Sequences multi-cycle data-memory accesses for the MEM stage of the 5-stage pipeline.
- Freezes the upstream pipeline registers (PC, IF/ID, ID/EX, EX/MEM) while a load/store waits for the memory's req/ack handshake.
- Forces bubbles into MEM/WB by clearing RegWrite/MemToReg, holds load data for MEM/WB capture, and flags a sticky bus error on timeout.

Parameters:
- TIMEOUT_CYCLES, 16, maximum number of WAIT cycles allowed for dmem_ack before entering ERROR (legal range 2..2^CNT_W).
- CNT_W, 4, width of the wait counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_read  input  1  MemRead of the instruction currently in EX/MEM.
- mem_write  input  1  MemWrite of the instruction currently in EX/MEM.
- dmem_req  output  1  request to data memory; registered.
- dmem_we  output  1  write qualifier for dmem_req; registered.
- dmem_ack  input  1  one-cycle completion pulse from data memory.
- dmem_rdata  input  32  read data, valid only in the dmem_ack cycle.
- rdata_out  output  32  held load data; drives MEM/WB ReadDataIn.
- pipe_en  output  1  enable for PC, IF/ID, ID/EX and EX/MEM registers.
- memwb_bubble  output  1  when 1, RegWriteIn/MemToRegIn of MEM/WB are forced to 0.
- bus_error  output  1  sticky timeout flag.
- err_clr  input  1  clears bus_error and releases ERROR.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, dmem_req=0, dmem_we=0, counter=0, rdata_out=0, bus_error=0.
- access = mem_read | mem_write. If both are set, the access is treated as a write (dmem_we=1).
- States: IDLE, WAIT, COMPLETE, ERROR, DRAIN.
- IDLE:
  - pipe_en = !access; memwb_bubble = access.
  - If access: go to WAIT next edge, set dmem_req=1, latch dmem_we=mem_write, counter=0.
  - dmem_ack in IDLE is ignored.
- WAIT:
  - pipe_en=0, memwb_bubble=1. dmem_req and dmem_we are held stable.
  - If dmem_ack: rdata_out<=dmem_rdata (reads only; writes leave rdata_out unchanged), dmem_req<=0, go to COMPLETE.
  - Else if counter==TIMEOUT_CYCLES-1: dmem_req<=0, bus_error<=1, go to ERROR.
  - Else counter<=counter+1.
  - If dmem_ack arrives in the same cycle as the timeout condition, ack wins.
- COMPLETE (exactly 1 cycle):
  - pipe_en=1, memwb_bubble=0. The access instruction advances into MEM/WB, capturing rdata_out.
  - Go to IDLE. A back-to-back access then appearing in EX/MEM is detected in that IDLE cycle (IDLE→WAIT, no idle gap beyond the single IDLE cycle).
- ERROR:
  - pipe_en=0, memwb_bubble=1; dmem_ack is ignored.
  - On err_clr: bus_error<=0, go to DRAIN.
- DRAIN (1 cycle):
  - pipe_en=1, memwb_bubble=1. The faulting instruction retires without writeback.
  - Go to IDLE.
- Latency: an access with ack in WAIT cycle k (k=1..TIMEOUT_CYCLES) occupies EX/MEM for k+2 cycles (IDLE detect + k WAIT + COMPLETE).
- busy=1 in WAIT, COMPLETE, ERROR, DRAIN.
- Reset mid-access: all state is dropped immediately; dmem_req falls asynchronously. Memory must tolerate an abandoned request.
- mem_read/mem_write are sampled only in IDLE; EX/MEM is frozen in other states, so they are stable by construction.

Test Plan:
- Reset: assert rst=0 mid-WAIT → dmem_req=0, bus_error=0, rdata_out=0, busy=0 immediately, with no clock required.
- Load, ack after 3 cycles: mem_read=1 at cycle 0, dmem_ack with dmem_rdata=32'hDEADBEEF in WAIT cycle 3 → pipe_en=0 for cycles 0–3, pipe_en=1 and memwb_bubble=0 at cycle 4, rdata_out=32'hDEADBEEF, dmem_we=0 throughout.
- Back-to-back store then load, ack in the first WAIT cycle each → sequence IDLE, WAIT, COMPLETE, IDLE, WAIT, COMPLETE; dmem_we=1 then 0; rdata_out unchanged after the store.
- Timeout: mem_write=1, no ack → after 16 WAIT cycles bus_error=1, dmem_req=0, state ERROR. A late ack is ignored. Pulsing err_clr gives one DRAIN cycle (pipe_en=1, memwb_bubble=1), then IDLE with bus_error=0.
- Ack and timeout coincide (ack in WAIT cycle 16) → COMPLETE, bus_error stays 0.
- mem_read=mem_write=1 → dmem_we=1; spurious dmem_ack while IDLE with no access → no state change, pipe_en=1.
